// File: rtl/multiport_register_bank.sv
// Multi-port register bank: 2 write ports (port 1 wins), NUM_RD read ports, busy scoreboard, reg 0 = 0.
// Latency: 1 cycle for reads, with write-first bypass of same-edge writes and busy updates.
// Backpressure: none; every port is accepted on every cycle, and outputs are registered only.
module multiport_register_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [1:0]                 wr_en,
  input  logic [ADDR_W-1:0]          wr_addr0,
  input  logic [DATA_W-1:0]          wr_data0,
  input  logic [ADDR_W-1:0]          wr_addr1,
  input  logic [DATA_W-1:0]          wr_data1,
  input  logic                       busy_set,
  input  logic [ADDR_W-1:0]          busy_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] rf_q;
  logic [DEPTH-1:0][DATA_W-1:0] rf_nxt;
  logic [DEPTH-1:0]             busy_q;
  logic [DEPTH-1:0]             busy_nxt;

  // Post-edge view of the bank. It is used both as the next state and as the read bypass
  // source, so a read always sees same-edge writes. Port 1 is applied after port 0, so it
  // wins an address collision. A busy_set is applied after the write clears, so it wins
  // against a write to the same register. Register 0 is never written and stays zero.
  always_comb begin
    rf_nxt   = rf_q;
    busy_nxt = busy_q;
    if (wr_en[0] && (wr_addr0 != '0)) begin
      rf_nxt[wr_addr0]   = wr_data0;
      busy_nxt[wr_addr0] = 1'b0;
    end
    if (wr_en[1] && (wr_addr1 != '0)) begin
      rf_nxt[wr_addr1]   = wr_data1;
      busy_nxt[wr_addr1] = 1'b0;
    end
    if (busy_set && (busy_addr != '0)) begin
      busy_nxt[busy_addr] = 1'b1;
    end
    rf_nxt[0]   = '0;
    busy_nxt[0] = 1'b0;
  end

  // State registers and registered read ports, all loaded from the post-edge view.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_q    <= '0;
      busy_q  <= '0;
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      rf_q   <= rf_nxt;
      busy_q <= busy_nxt;
      for (int i = 0; i < NUM_RD; i++) begin
        rd_data[i*DATA_W +: DATA_W] <= rf_nxt[rd_addr[i*ADDR_W +: ADDR_W]];
        rd_busy[i]                  <= busy_nxt[rd_addr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule

// File: tb/tb_multiport_register_bank.sv
// Directed-vector bench for multiport_register_bank with a queue-based scoreboard.
// Each stimulus cycle pushes its hand-computed read result, and a monitor pops and compares it after the edge.
// Reset behaviour is checked directly while reset is held low.
module tb_multiport_register_bank;

  logic        clock;
  logic        reset;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [2:0]  wr_addr0;
  logic [7:0]  wr_data0;
  logic [2:0]  wr_addr1;
  logic [7:0]  wr_data1;
  logic        busy_set;
  logic [2:0]  busy_addr;

  typedef struct {
    logic [7:0] d0;
    logic       b0;
    logic [7:0] d1;
    logic       b1;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  multiport_register_bank #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr0  (wr_addr0),
    .wr_data0  (wr_data0),
    .wr_addr1  (wr_addr1),
    .wr_data1  (wr_data1),
    .busy_set  (busy_set),
    .busy_addr (busy_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the bank answers every cycle, so one queued expectation is consumed per edge.
  always @(posedge clock) begin
    #1;
    if (reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, " rd_data0"}, rd_data[7:0],  e.d0);
      check({e.tag, " rd_busy0"}, {7'd0, rd_busy[0]}, {7'd0, e.b0});
      check({e.tag, " rd_data1"}, rd_data[15:8], e.d1);
      check({e.tag, " rd_busy1"}, {7'd0, rd_busy[1]}, {7'd0, e.b1});
    end
  end

  task automatic idle();
    wr_en = 2'b00; wr_addr0 = '0; wr_data0 = '0; wr_addr1 = '0; wr_data1 = '0;
    busy_set = 1'b0; busy_addr = '0; rd_addr = '0;
  endtask

  // One cycle of stimulus plus the read result expected just after the following edge.
  task automatic cyc(input string tag,
                     input logic [1:0] we, input logic [2:0] a0, input logic [7:0] d0,
                     input logic [2:0] a1, input logic [7:0] d1,
                     input logic bs, input logic [2:0] ba,
                     input logic [2:0] r0, input logic [2:0] r1,
                     input logic [7:0] e0, input logic eb0,
                     input logic [7:0] e1, input logic eb1);
    exp_t e;
    @(negedge clock);
    wr_en = we; wr_addr0 = a0; wr_data0 = d0; wr_addr1 = a1; wr_data1 = d1;
    busy_set = bs; busy_addr = ba; rd_addr = {r1, r0};
    e.d0 = e0; e.b0 = eb0; e.d1 = e1; e.b1 = eb1; e.tag = tag;
    exp_q.push_back(e);
  endtask

  initial begin
    int guard;
    idle();
    reset = 1'b0;
    #1;
    check("reset rd_data", rd_data[7:0] | rd_data[15:8], 8'h00);
    check("reset rd_busy", {6'd0, rd_busy}, 8'h00);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Preload regs 1 and 6. Reg 6 gets a write and a busy_set on the same edge, and the set wins.
    cyc("preload", 2'b11, 3'd1, 8'h10, 3'd6, 8'h60, 1'b1, 3'd6, 3'd1, 3'd6, 8'h10, 1'b0, 8'h60, 1'b1);
    cyc("preload hold", 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd6, 8'h10, 1'b0, 8'h60, 1'b1);
    @(negedge clock);
    idle();
    rd_addr = {3'd6, 3'd1};
    @(posedge clock);
    #3;
    // Asserting reset mid-cycle clears the outputs immediately.
    reset = 1'b0;
    #1;
    check("midreset rd_data0", rd_data[7:0],  8'h00);
    check("midreset rd_data1", rd_data[15:8], 8'h00);
    check("midreset rd_busy",  {6'd0, rd_busy}, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cyc("post-reset 0/1", 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd1, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc("post-reset 2/3", 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd3, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc("post-reset 4/5", 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd5, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc("post-reset 6/7", 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd7, 8'h00, 1'b0, 8'h00, 1'b0);

    // Basic write, followed by a read on the next cycle.
    cyc("write 3",   2'b01, 3'd3, 8'hA5, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc("read 3",    2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd0, 8'hA5, 1'b0, 8'h00, 1'b0);
    // Write-first bypass on read port 1.
    cyc("bypass 5",  2'b01, 3'd5, 8'h3C, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd5, 8'hA5, 1'b0, 8'h3C, 1'b0);
    // Write-port collision: port 1 wins in both the bank and the bypass.
    cyc("collide 2", 2'b11, 3'd2, 8'h11, 3'd2, 8'h22, 1'b0, 3'd0, 3'd2, 3'd5, 8'h22, 1'b0, 8'h3C, 1'b0);
    cyc("read 2/3",  2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd3, 8'h22, 1'b0, 8'hA5, 1'b0);
    // Register zero ignores writes and busy_set.
    cyc("zero wr",   2'b11, 3'd0, 8'hFF, 3'd0, 8'hEE, 1'b1, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc("zero rd",   2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd2, 8'h00, 1'b0, 8'h22, 1'b0);
    // Busy scoreboard: set, clear by write, then set winning over a same-cycle write.
    cyc("busy set4", 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd3, 8'h00, 1'b1, 8'hA5, 1'b0);
    cyc("busy hold", 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd4, 8'hA5, 1'b0, 8'h00, 1'b1);
    cyc("busy clr4", 2'b10, 3'd0, 8'h00, 3'd4, 8'h44, 1'b0, 3'd0, 3'd4, 3'd4, 8'h44, 1'b0, 8'h44, 1'b0);
    cyc("busy both", 2'b01, 3'd4, 8'h77, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd4, 8'h77, 1'b1, 8'h77, 1'b1);
    cyc("busy keep", 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd1, 8'h77, 1'b1, 8'h00, 1'b0);
    @(negedge clock);
    idle();

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
